// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : stack_sequencer
//  Purpose  : Sequencer for a small stack machine. Holds program memory,
//             the 16-entry stack, pc/sp/opcode, and steps
//             HALT -> FETCH -> EXEC (-> SLEEP) while an external execute unit
//             computes the next architectural state.
//  Revision : 1.0 - initial release
// ============================================================================
module stack_sequencer #(
    parameter int SLEEP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       load_en,
    input  logic [5:0] load_addr,
    input  logic [7:0] load_data,
    output logic [3:0] opcode,
    output logic [5:0] pc,
    output logic [3:0] sp,
    output logic [7:0] top,
    output logic [7:0] btop,
    output logic [7:0] pmem_in,
    input  logic [5:0] pc_plus,
    input  logic [3:0] sp_min,
    input  logic [7:0] sp_w_cnt,
    input  logic [7:0] new_top,
    input  logic [7:0] new_btop,
    input  logic       pmem_we,
    input  logic [5:0] pmem_w_addr,
    input  logic [7:0] pmem_out,
    input  logic       sleep,
    input  logic       stop,
    output logic       halted,
    output logic       sleeping,
    output logic       running
);

    localparam logic [7:0] c_sleep_load = 8'(SLEEP_CYCLES);

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        SLEEP = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_pmem  [0:63];
    logic [7:0] r_stack [0:15];
    logic [5:0] r_pc;
    logic [3:0] r_sp;
    logic [3:0] r_opcode;
    logic [7:0] r_sleep_cnt;

    logic [3:0] w_top_idx;
    logic [3:0] w_btop_idx;
    logic [3:0] w_wr1_idx;
    logic [3:0] w_wr2_idx;
    logic       w_exec;
    logic       w_pmem_we;
    logic [5:0] w_pmem_addr;
    logic [7:0] w_pmem_data;

    // Stack-relative indices; 4-bit arithmetic gives the modulo-16 wrap.
    assign w_top_idx  = r_sp - 4'd1;
    assign w_btop_idx = r_sp - 4'd2;
    assign w_wr1_idx  = sp_min - 4'd1;
    assign w_wr2_idx  = sp_min - 4'd2;
    assign w_exec     = (r_state == EXEC);

    assign opcode   = r_opcode;
    assign pc       = r_pc;
    assign sp       = r_sp;
    assign top      = r_stack[w_top_idx];
    assign btop     = r_stack[w_btop_idx];
    assign pmem_in  = r_pmem[top[5:0]];
    assign halted   = (r_state == HALT);
    assign sleeping = (r_state == SLEEP);
    assign running  = (r_state == FETCH) || (r_state == EXEC);

    // Single program-memory write port shared by the loader (HALT only,
    // start has priority) and the execute-unit commit in EXEC.
    always_comb begin
        w_pmem_we   = 1'b0;
        w_pmem_addr = load_addr;
        w_pmem_data = load_data;
        if (r_state == HALT) begin
            w_pmem_we = load_en && !start;
        end else if (w_exec && pmem_we) begin
            w_pmem_we   = 1'b1;
            w_pmem_addr = pmem_w_addr;
            w_pmem_data = pmem_out;
        end
    end

    // Program memory is not reset; gating on rst_n blocks a write racing reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_pmem_we) begin
            r_pmem[w_pmem_addr] <= w_pmem_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; stop outranks sleep at the EXEC commit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HALT:    if (start) w_state_nxt = FETCH;
            FETCH:   w_state_nxt = EXEC;
            EXEC: begin
                if (stop)       w_state_nxt = HALT;
                else if (sleep) w_state_nxt = SLEEP;
                else            w_state_nxt = FETCH;
            end
            SLEEP:   if (r_sleep_cnt <= 8'd1) w_state_nxt = FETCH;
            default: w_state_nxt = HALT;
        endcase
    end

    // Sleep down-counter: loaded on entry, last SLEEP cycle is count==1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sleep_cnt <= 8'd0;
        end else if (w_exec && !stop && sleep) begin
            r_sleep_cnt <= c_sleep_load;
        end else if (r_state == SLEEP && r_sleep_cnt != 8'd0) begin
            r_sleep_cnt <= r_sleep_cnt - 8'd1;
        end
    end

    // Opcode capture in FETCH (low nibble only) and pc/sp commit in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= 4'd0;
            r_pc     <= 6'd0;
            r_sp     <= 4'd0;
        end else begin
            if (r_state == FETCH) begin
                r_opcode <= r_pmem[r_pc][3:0];
            end
            if (w_exec) begin
                r_pc <= pc_plus;
                r_sp <= sp_min;
            end
        end
    end

    // Stack writes at commit: one or two entries below the new sp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_stack[i] <= 8'd0;
            end
        end else if (w_exec) begin
            if (sp_w_cnt == 8'd1) begin
                r_stack[w_wr1_idx] <= new_top;
            end else if (sp_w_cnt == 8'd2) begin
                r_stack[w_wr1_idx] <= new_top;
                r_stack[w_wr2_idx] <= new_btop;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_sequencer
//  Purpose  : Directed scoreboard bench for stack_sequencer with a small
//             reference execute unit (push-literal / add / sleep / stop).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       load_en;
    logic [5:0] load_addr;
    logic [7:0] load_data;
    logic [3:0] opcode;
    logic [5:0] pc;
    logic [3:0] sp;
    logic [7:0] top;
    logic [7:0] btop;
    logic [7:0] pmem_in;
    logic [5:0] pc_plus;
    logic [3:0] sp_min;
    logic [7:0] sp_w_cnt;
    logic [7:0] new_top;
    logic [7:0] new_btop;
    logic       pmem_we;
    logic [5:0] pmem_w_addr;
    logic [7:0] pmem_out;
    logic       sleep;
    logic       stop;
    logic       halted;
    logic       sleeping;
    logic       running;

    // Execute-unit source select: reference model or directed values.
    logic       use_ref;
    logic [5:0] m_pc_plus;
    logic [3:0] m_sp_min;
    logic [7:0] m_cnt;
    logic [7:0] m_new_top;
    logic [7:0] m_new_btop;
    logic       m_pmem_we;
    logic [5:0] m_pmem_w_addr;
    logic [7:0] m_pmem_out;
    logic       m_sleep;
    logic       m_stop;

    logic [5:0] ref_pc_plus;
    logic [3:0] ref_sp_min;
    logic [7:0] ref_cnt;
    logic [7:0] ref_new_top;
    logic       ref_sleep;
    logic       ref_stop;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    stack_sequencer #(.SLEEP_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .opcode      (opcode),
        .pc          (pc),
        .sp          (sp),
        .top         (top),
        .btop        (btop),
        .pmem_in     (pmem_in),
        .pc_plus     (pc_plus),
        .sp_min      (sp_min),
        .sp_w_cnt    (sp_w_cnt),
        .new_top     (new_top),
        .new_btop    (new_btop),
        .pmem_we     (pmem_we),
        .pmem_w_addr (pmem_w_addr),
        .pmem_out    (pmem_out),
        .sleep       (sleep),
        .stop        (stop),
        .halted      (halted),
        .sleeping    (sleeping),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference execute unit: 0=add, 0xE=sleep, 0xF=stop, else push opcode value.
    always_comb begin
        ref_pc_plus = pc + 6'd1;
        ref_sp_min  = sp;
        ref_cnt     = 8'd0;
        ref_new_top = 8'd0;
        ref_sleep   = 1'b0;
        ref_stop    = 1'b0;
        case (opcode)
            4'h0: begin
                ref_sp_min  = sp - 4'd1;
                ref_cnt     = 8'd1;
                ref_new_top = top + btop;
            end
            4'hE: ref_sleep = 1'b1;
            4'hF: ref_stop  = 1'b1;
            default: begin
                ref_sp_min  = sp + 4'd1;
                ref_cnt     = 8'd1;
                ref_new_top = {4'h0, opcode};
            end
        endcase
    end

    assign pc_plus     = use_ref ? ref_pc_plus : m_pc_plus;
    assign sp_min      = use_ref ? ref_sp_min  : m_sp_min;
    assign sp_w_cnt    = use_ref ? ref_cnt     : m_cnt;
    assign new_top     = use_ref ? ref_new_top : m_new_top;
    assign new_btop    = use_ref ? 8'd0        : m_new_btop;
    assign pmem_we     = use_ref ? 1'b0        : m_pmem_we;
    assign pmem_w_addr = m_pmem_w_addr;
    assign pmem_out    = m_pmem_out;
    assign sleep       = use_ref ? ref_sleep   : m_sleep;
    assign stop        = use_ref ? ref_stop    : m_stop;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic load(input logic [5:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic set_manual(input logic [5:0] pcp, input logic [3:0] spm,
                              input logic [7:0] cnt, input logic [7:0] nt,
                              input logic [7:0] nb);
        m_pc_plus  = pcp;
        m_sp_min   = spm;
        m_cnt      = cnt;
        m_new_top  = nt;
        m_new_btop = nb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_sleep;
        rst_n = 1'b0; start = 1'b0; load_en = 1'b0;
        load_addr = 6'd0; load_data = 8'd0; use_ref = 1'b0;
        m_pmem_we = 1'b0; m_pmem_w_addr = 6'd0; m_pmem_out = 8'd0;
        m_sleep = 1'b0; m_stop = 1'b0;
        set_manual(6'd0, 4'd0, 8'd0, 8'd0, 8'd0);

        // Reset state
        expect_val("rst_halted", 1); expect_val("rst_pc", 0); expect_val("rst_sp", 0);
        expect_val("rst_opcode", 0); expect_val("rst_top", 0); expect_val("rst_running", 0);
        @(negedge clk);
        pop_check(halted); pop_check(pc); pop_check(sp);
        pop_check(opcode); pop_check(top); pop_check(running);
        rst_n = 1'b1;
        tick();

        // Program load while halted
        load(6'd0, 8'h0D); load(6'd1, 8'h0D); load(6'd2, 8'h00); load(6'd3, 8'h0F);
        load(6'd4, 8'h01); load(6'd5, 8'h03); load(6'd6, 8'h04); load(6'd9, 8'h07);
        expect_val("idle_halted", 1); expect_val("idle_pc", 0);
        pop_check(halted); pop_check(pc);

        // Reference program: push 0xD, push 0xD, add, stop
        use_ref = 1'b1;
        start   = 1'b1;
        expect_val("start_running", 1);
        tick();
        start = 1'b0;
        pop_check(running);
        expect_val("fetch0_opcode", 4'hD);
        tick();
        pop_check(opcode);
        repeat (7) tick();
        expect_val("prog_halted", 1); expect_val("prog_sp", 1);
        expect_val("prog_top", 8'h1A); expect_val("prog_pc", 4);
        pop_check(halted); pop_check(sp); pop_check(top); pop_check(pc);

        // start and load_en together: start wins, pmem[5] not written
        use_ref = 1'b0;
        set_manual(6'd5, 4'd1, 8'd1, 8'h05, 8'h00);
        start = 1'b1; load_en = 1'b1; load_addr = 6'd5; load_data = 8'hAA;
        expect_val("both_running", 1);
        tick();
        start = 1'b0; load_en = 1'b0;
        pop_check(running);
        expect_val("pc4_opcode", 4'h1);
        tick();
        pop_check(opcode);
        expect_val("both_pc", 5); expect_val("both_top", 8'h05); expect_val("pmem5_kept", 8'h03);
        tick();
        pop_check(pc); pop_check(top); pop_check(pmem_in);
        expect_val("pc5_opcode", 4'h3);
        tick();
        pop_check(opcode);

        // Sleep for exactly SLEEP_CYCLES then fetch at pc_plus
        set_manual(6'd6, 4'd1, 8'd0, 8'h00, 8'h00);
        m_sleep = 1'b1;
        tick();
        m_sleep = 1'b0;
        n_sleep = 0;
        for (int i = 0; i < 40; i++) begin
            if (!sleeping) break;
            n_sleep++;
            tick();
        end
        expect_val("sleep_len", 16); expect_val("wake_running", 1); expect_val("wake_pc", 6);
        pop_check(n_sleep); pop_check(running); pop_check(pc);
        expect_val("wake_opcode", 4'h4);
        tick();
        pop_check(opcode);

        // stop and sleep together: stop wins
        set_manual(6'd7, 4'd1, 8'd0, 8'h00, 8'h00);
        m_stop = 1'b1; m_sleep = 1'b1;
        expect_val("stop_halted", 1); expect_val("stop_sleeping", 0);
        tick();
        m_stop = 1'b0; m_sleep = 1'b0;
        pop_check(halted); pop_check(sleeping);
        expect_val("stop_sleeping2", 0); expect_val("stop_pc", 7);
        tick();
        pop_check(sleeping); pop_check(pc);

        // Two-entry stack write wrapping below index 0
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        set_manual(6'd1, 4'd1, 8'd2, 8'h11, 8'h22);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_val("w2_sp", 1); expect_val("w2_top", 8'h11); expect_val("w2_btop", 8'h22);
        tick();
        pop_check(sp); pop_check(top); pop_check(btop);

        // sp_w_cnt outside 1..2 writes nothing
        set_manual(6'd2, 4'd2, 8'd3, 8'h77, 8'h66);
        tick();
        expect_val("w3_sp", 2); expect_val("w3_top", 8'h00); expect_val("w3_btop", 8'h11);
        tick();
        pop_check(sp); pop_check(top); pop_check(btop);

        // Reset during EXEC with a pending pmem write
        m_pmem_we = 1'b1; m_pmem_w_addr = 6'd9; m_pmem_out = 8'h55;
        tick();
        rst_n = 1'b0;
        expect_val("arst_halted", 1); expect_val("arst_pc", 0); expect_val("arst_sp", 0);
        #1;
        pop_check(halted); pop_check(pc); pop_check(sp);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_pmem_we = 1'b0;
        set_manual(6'd1, 4'd1, 8'd1, 8'h09, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_val("pmem9_kept", 8'h07);
        tick();
        pop_check(pmem_in);

        // EXEC write to pmem[pc_plus] visible to the very next FETCH
        tick();
        set_manual(6'd2, 4'd1, 8'd0, 8'h00, 8'h00);
        m_pmem_we = 1'b1; m_pmem_w_addr = 6'd2; m_pmem_out = 8'h0B;
        tick();
        m_pmem_we = 1'b0;
        expect_val("wr_fwd_opcode", 4'hB);
        tick();
        pop_check(opcode);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter SLEEP_CYCLES, default 16, number of clocks spent in SLEEP per sleep opcode (range 1..255).
REQ-002 SHALL have ports: clk  input  1  rising-edge system clock.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have: start  input  1  pulse; leaves HALT and begins fetching at current pc.
REQ-005 SHALL have: load_en  input  1; load_addr  input  6; load_data  input  8; external program-memory write port.
REQ-006 SHALL have, toward the execute unit: opcode  output  4; pc  output  6; sp  output  4; top  output  8; btop  output  8; pmem_in  output  8.
REQ-007 SHALL have, from the execute unit: pc_plus  input  6; sp_min  input  4; sp_w_cnt  input  8; new_top  input  8; new_btop  input  8; pmem_we  input  1; pmem_w_addr  input  6; pmem_out  input  8; sleep  input  1; stop  input  1.
REQ-008 SHALL have status: halted  output  1; sleeping  output  1; running  output  1 (FETCH or EXEC).

Function
REQ-009 SHALL hold a 64x8 program memory, a 16x8 stack array, a 6-bit pc register, a 4-bit sp register and a 4-bit opcode register.
REQ-010 top SHALL be stack[sp-1], btop SHALL be stack[sp-2], indices modulo 16 (sp=0 -> top=stack[15], btop=stack[14]); combinational from registers.
REQ-011 pmem_in SHALL be program memory at address top[5:0], combinational.
REQ-012 FSM states: HALT, FETCH, EXEC, SLEEP; one state per clock.
REQ-013 HALT: start=1 -> FETCH; else stay; load_en=1 and start=0 -> pmem[load_addr] <= load_data.
REQ-014 load_en outside HALT SHALL be ignored; start outside HALT SHALL be ignored; start and load_en together in HALT -> start wins, no write.
REQ-015 FETCH: opcode <= pmem[pc][3:0] (upper nibble ignored); -> EXEC.
REQ-016 EXEC (commit cycle, using execute-unit inputs): pc <= pc_plus; sp <= sp_min.
REQ-017 EXEC: sp_w_cnt==1 -> stack[sp_min-1] <= new_top; sp_w_cnt==2 -> additionally stack[sp_min-2] <= new_btop; other values -> no stack write; indices modulo 16.
REQ-018 EXEC: pmem_we=1 -> pmem[pmem_w_addr] <= pmem_out.
REQ-019 EXEC next state: stop=1 -> HALT (stop has priority over sleep); else sleep=1 -> SLEEP; else FETCH.
REQ-020 SLEEP: 8-bit down-counter loaded with SLEEP_CYCLES on entry; returns to FETCH after exactly SLEEP_CYCLES clocks in SLEEP; pc/sp/stack unchanged.
REQ-021 Throughput: 2 clocks per non-sleep instruction (FETCH+EXEC).
REQ-022 pc and sp wrap modulo 64 / 16 with no error flag; stack over/underflow silently wraps.
REQ-023 A pmem write in EXEC to address pc_plus SHALL be seen by the immediately following FETCH.
REQ-024 halted = (state==HALT); sleeping = (state==SLEEP); running = FETCH or EXEC.

Reset
REQ-025 rst_n low SHALL immediately force: state HALT, pc 0, sp 0, opcode 0, all 16 stack entries 0, sleep counter 0.
REQ-026 Program memory SHALL NOT be reset; contents survive rst_n.
REQ-027 Reset mid-instruction (FETCH/EXEC/SLEEP) SHALL discard the in-flight commit; no partial stack or pmem write.
REQ-028 After rst_n release, block SHALL remain in HALT until start.

Verification
REQ-029 Load pmem[0]=0x0D,[1]=0x0D,[2]=0x00,[3]=0x0F via load port; start with a reference execute unit -> after 8 clocks halted=1, sp=1, top=0x1A, pc=4.
REQ-030 start and load_en both high in HALT with load_addr=5, load_data=0xAA -> FETCH entered, pmem[5] unchanged.
REQ-031 EXEC with sleep=1 and SLEEP_CYCLES=16 -> sleeping=1 for exactly 16 clocks, then FETCH at pc_plus.
REQ-032 EXEC with stop=1 and sleep=1 together -> HALT next clock, sleeping never asserted.
REQ-033 sp=0, sp_w_cnt=2, sp_min=1, new_top=0x11, new_btop=0x22 -> stack[0]=0x11, stack[15]=0x22, sp=1.
REQ-034 rst_n asserted during EXEC with pmem_we=1, pmem_w_addr=9 -> pmem[9] unchanged, halted=1, pc=0, sp=0 immediately.
